// File: rtl/ifetch_stage_pkg.sv
// ifetch_stage_pkg
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// instruction width in bytes, the NOP encoding used as the IF/ID reset
// value, and the redirect-target legality check.
package ifetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } if_state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR   = 32'd0;

  // A redirect target is legal when it is word-aligned and not past the last word.
  function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] last_pc);
    return (pc[1:0] == 2'b00) && (pc <= last_pc);
  endfunction

endpackage

// File: rtl/ifetch_stage_if_id_reg.sv
// ifetch_stage_if_id_reg
// IF/ID pipeline register. clr drops the valid bit while the data fields
// hold; load captures a new instruction and marks it valid; with neither
// asserted everything holds (stall).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load, clr       capture enable / invalidate (clr has priority)
//   instr, pc, pc4  word and addresses to capture
//   id_instr, id_pc, id_pc4, id_valid  registered outputs
module ifetch_stage_if_id_reg
  import ifetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clr,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  logic [31:0] instr_r;
  logic [31:0] pc_r;
  logic [31:0] pc4_r;
  logic        valid_r;

  // IF/ID register update: clear-valid, load, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r <= NOP_INSTR;
      pc_r    <= 32'd0;
      pc4_r   <= 32'd0;
      valid_r <= 1'b0;
    end else if (clr) begin
      valid_r <= 1'b0;
    end else if (load) begin
      instr_r <= instr;
      pc_r    <= pc;
      pc4_r   <= pc4;
      valid_r <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign id_instr = instr_r;
  assign id_pc    = pc_r;
  assign id_pc4   = pc4_r;
  assign id_valid = valid_r;

endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage
// Instruction-fetch stage: owns the PC and the RUN/HALT/FAULT FSM, drives
// the combinational instruction-memory read port and feeds the IF/ID register.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   RAdrs, ITM           memory byte address (= PC) / returned word
//   stall, flush         decode-stage hold / invalidate
//   redirect, redirect_pc execute-stage branch/jump target
//   id_instr, id_pc, id_pc4, id_valid  IF/ID register outputs
//   halted, fault        FSM status (fault is sticky until reset)
module ifetch_stage
  import ifetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned IMEM_BYTES = 400
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] RAdrs,
  input  logic [31:0] ITM,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES) - INSTR_BYTES;

  if_state_t   state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] pc_plus4_s;
  logic        load_s;
  logic        clr_s;

  assign pc_plus4_s = pc_r + INSTR_BYTES;

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
    end
  end

  // Next-state / next-PC and IF/ID control; priority redirect > flush > stall > fetch.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    load_s  = 1'b0;
    clr_s   = 1'b0;
    case (state_r)
      ST_RUN, ST_HALT: begin
        if (redirect) begin
          clr_s = 1'b1;
          if (pc_legal(redirect_pc, LAST_PC)) begin
            pc_s    = redirect_pc;
            state_s = ST_RUN;
          end else begin
            state_s = ST_FAULT;
          end
        end else if (flush) begin
          clr_s = 1'b1;
        end else if (stall) begin
          clr_s = 1'b0;
        end else if (state_r == ST_RUN) begin
          load_s = 1'b1;
          if (pc_r == LAST_PC) begin
            state_s = ST_HALT;
          end else begin
            pc_s = pc_plus4_s;
          end
        end else begin
          // Halted with nothing to do: emit bubbles.
          clr_s = 1'b1;
        end
      end
      ST_FAULT: begin
        clr_s = 1'b1;
      end
      default: begin
        // Unreachable encoding: fail safe.
        state_s = ST_FAULT;
        clr_s   = 1'b1;
      end
    endcase
  end

  ifetch_stage_if_id_reg u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .clr      (clr_s),
    .instr    (ITM),
    .pc       (pc_r),
    .pc4      (pc_plus4_s),
    .id_instr (id_instr),
    .id_pc    (id_pc),
    .id_pc4   (id_pc4),
    .id_valid (id_valid)
  );

  assign RAdrs  = pc_r;
  assign halted = (state_r == ST_HALT);
  assign fault  = (state_r == ST_FAULT);

endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage
// Directed bench for ifetch_stage: a combinational memory model returns a
// distinct word per address; each step checks outputs 1 ns after the edge.
module tb_ifetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] RAdrs;
  logic [31:0] ITM;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        halted;
  logic        fault;

  int total;
  int bad;
  logic [31:0] exp_pc;

  ifetch_stage #(.RESET_PC(32'd0), .IMEM_BYTES(400)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RAdrs       (RAdrs),
    .ITM         (ITM),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .id_valid    (id_valid),
    .halted      (halted),
    .fault       (fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  assign ITM = mem_word(RAdrs);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;

    // Reset state
    #12;
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_pc", id_pc, 32'd0);
    check("rst_pc4", id_pc4, 32'd0);
    check("rst_instr", id_instr, 32'd0);
    check("rst_radrs", RAdrs, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    rst_n = 1'b1;

    // Free-run first two fetches
    step();
    check("f0_pc", id_pc, 32'd0);
    check("f0_instr", id_instr, 32'hC0DE_0000);
    check("f0_pc4", id_pc4, 32'd4);
    check("f0_valid", {31'd0, id_valid}, 32'd1);
    check("f0_radrs", RAdrs, 32'd4);
    step();
    check("f1_pc", id_pc, 32'd4);
    check("f1_instr", id_instr, 32'hC0DE_0004);
    check("f1_radrs", RAdrs, 32'd8);

    // Stall three cycles at PC=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", id_pc, 32'd4);
      check("stall_valid", {31'd0, id_valid}, 32'd1);
      check("stall_radrs", RAdrs, 32'd8);
    end
    stall = 1'b0;
    step();
    check("resume_pc", id_pc, 32'd8);
    check("resume_instr", id_instr, 32'hC0DE_0008);
    check("resume_radrs", RAdrs, 32'd12);

    // Redirect to 100 with stall also high
    redirect = 1'b1;
    redirect_pc = 32'd100;
    stall = 1'b1;
    step();
    check("redir_bubble", {31'd0, id_valid}, 32'd0);
    check("redir_radrs", RAdrs, 32'd100);
    redirect = 1'b0;
    stall = 1'b0;
    step();
    check("redir_pc", id_pc, 32'd100);
    check("redir_pc4", id_pc4, 32'd104);
    check("redir_instr", id_instr, 32'hC0DE_0064);
    check("redir_valid", {31'd0, id_valid}, 32'd1);

    // Flush with stall: flush wins, PC holds
    flush = 1'b1;
    stall = 1'b1;
    step();
    check("flush_valid", {31'd0, id_valid}, 32'd0);
    check("flush_radrs", RAdrs, 32'd104);
    check("flush_idpc", id_pc, 32'd100);
    flush = 1'b0;
    stall = 1'b0;

    // Run to the end of memory: 104..396 is 74 fetches
    exp_pc = 32'd104;
    repeat (74) begin
      step();
      check("run_pc", id_pc, exp_pc);
      check("run_instr", id_instr, 32'hC0DE_0000 | exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
    check("end_halted", {31'd0, halted}, 32'd1);
    check("end_valid", {31'd0, id_valid}, 32'd1);
    check("end_radrs", RAdrs, 32'd396);
    check("end_pc4", id_pc4, 32'd400);
    step();
    check("halt_valid", {31'd0, id_valid}, 32'd0);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_radrs", RAdrs, 32'd396);
    check("halt_idpc", id_pc, 32'd396);

    // Redirect out of HALT to 20
    redirect = 1'b1;
    redirect_pc = 32'd20;
    step();
    check("unhalt_halted", {31'd0, halted}, 32'd0);
    check("unhalt_valid", {31'd0, id_valid}, 32'd0);
    check("unhalt_radrs", RAdrs, 32'd20);
    redirect = 1'b0;
    step();
    check("unhalt_pc", id_pc, 32'd20);
    check("unhalt_instr", id_instr, 32'hC0DE_0014);
    check("unhalt_valid2", {31'd0, id_valid}, 32'd1);

    // Misaligned redirect faults; PC holds at 24
    redirect = 1'b1;
    redirect_pc = 32'd102;
    step();
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_valid", {31'd0, id_valid}, 32'd0);
    check("mis_radrs", RAdrs, 32'd24);
    check("mis_idpc", id_pc, 32'd20);
    // Legal redirect while faulted is ignored
    redirect_pc = 32'd0;
    step();
    check("ign_fault", {31'd0, fault}, 32'd1);
    check("ign_radrs", RAdrs, 32'd24);
    redirect = 1'b0;
    step();
    check("ign_valid", {31'd0, id_valid}, 32'd0);
    check("ign_fault2", {31'd0, fault}, 32'd1);

    // Asynchronous reset pulse between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_fault", {31'd0, fault}, 32'd0);
    check("arst_idpc", id_pc, 32'd0);
    check("arst_instr", id_instr, 32'd0);
    check("arst_radrs", RAdrs, 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_pc", id_pc, 32'd0);
    check("post_rst_valid", {31'd0, id_valid}, 32'd1);
    step();
    check("post_rst_pc2", id_pc, 32'd4);

    // Redirect past the last word faults
    redirect = 1'b1;
    redirect_pc = 32'd400;
    step();
    check("oob_fault", {31'd0, fault}, 32'd1);
    check("oob_valid", {31'd0, id_valid}, 32'd0);
    check("oob_radrs", RAdrs, 32'd8);
    redirect = 1'b0;

    // Boundary: 396 is a legal target after reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'd396;
    step();
    check("last_fault", {31'd0, fault}, 32'd0);
    check("last_radrs", RAdrs, 32'd396);
    redirect = 1'b0;
    step();
    check("last_pc", id_pc, 32'd396);
    check("last_halted", {31'd0, halted}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
